// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle between an SPI controller and the register-file target.
// The controller drives sclk/ncs/copi; the target drives cipo and its pad enable.
interface spi_regfile_peripheral_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output ncs, output copi, input cipo, input cipo_oe);
  modport slave  (input sclk, input ncs, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target owning NUM_REGS x DATA_W control registers with write, read-back
// and auto-incrementing bursts; every SPI input is oversampled in the clk domain.
module spi_regfile_peripheral #(
  parameter int                NUM_REGS    = 5,
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 7,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = {DATA_W{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_regfile_peripheral_if.slave      spi,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          wr_stb,
  output logic                         frame_err
);

  localparam int MAX_BITS = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [SYNC_STAGES:0]    sclk_sync_r;
  logic [SYNC_STAGES:0]    ncs_sync_r;
  logic [SYNC_STAGES-1:0]  copi_sync_r;
  logic                    sclk_rise_s, sclk_fall_s, ncs_fall_s, ncs_rise_s, copi_s;
  logic                    hdr_last_s, word_last_s, err_s;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic                    rw_r;
  logic [ADDR_W-1:0]       ptr_r;
  logic [DATA_W-1:0]       shift_r;
  logic                    commit_r;
  logic                    rd_load_r;
  logic                    rd_hold_r;
  logic [DATA_W-1:0]       rd_shift_r;
  logic [DATA_W-1:0]       rd_word_s;
  logic                    cipo_oe_r;
  logic [NUM_REGS-1:0]     wr_stb_r;
  logic                    frame_err_r;
  logic [DATA_W-1:0]       regs_r [NUM_REGS];

  // Synchronisers; the extra top bit of sclk/ncs is the previous value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= {(SYNC_STAGES+1){1'b0}};
      ncs_sync_r  <= {(SYNC_STAGES+1){1'b1}};
      copi_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-1:0], spi.sclk};
      ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-1:0], spi.ncs};
      copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], spi.copi};
    end
  end

  assign sclk_rise_s =  sclk_sync_r[SYNC_STAGES-1] & ~sclk_sync_r[SYNC_STAGES];
  assign sclk_fall_s = ~sclk_sync_r[SYNC_STAGES-1] &  sclk_sync_r[SYNC_STAGES];
  assign ncs_fall_s  = ~ncs_sync_r[SYNC_STAGES-1]  &  ncs_sync_r[SYNC_STAGES];
  assign ncs_rise_s  =  ncs_sync_r[SYNC_STAGES-1]  & ~ncs_sync_r[SYNC_STAGES];
  assign copi_s      =  copi_sync_r[SYNC_STAGES-1];

  // Read-back mux; unimplemented addresses return zero.
  always_comb begin
    rd_word_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_word_s = (ptr_r == ADDR_W'(i)) ? regs_r[i] : rd_word_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and frame events; ncs rise wins over any coincident sclk edge.
  always_comb begin
    state_nxt_s = state_r;
    hdr_last_s  = 1'b0;
    word_last_s = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (ncs_fall_s) begin
          state_nxt_s = CMD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CMD: begin
        if (ncs_rise_s) begin
          state_nxt_s = IDLE;
          err_s       = 1'b1;
        end else if (sclk_rise_s && (bit_cnt_r == CNT_W'(ADDR_W))) begin
          state_nxt_s = DATA;
          hdr_last_s  = 1'b1;
        end else begin
          state_nxt_s = CMD;
        end
      end
      DATA: begin
        if (ncs_rise_s) begin
          state_nxt_s = IDLE;
          err_s       = (bit_cnt_r != {CNT_W{1'b0}});
        end else begin
          state_nxt_s = DATA;
          word_last_s = sclk_rise_s && (bit_cnt_r == CNT_W'(DATA_W - 1));
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath: header capture, word assembly, register commit and read shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r   <= {CNT_W{1'b0}};
      rw_r        <= 1'b0;
      ptr_r       <= {ADDR_W{1'b0}};
      shift_r     <= {DATA_W{1'b0}};
      commit_r    <= 1'b0;
      rd_load_r   <= 1'b0;
      rd_hold_r   <= 1'b0;
      rd_shift_r  <= {DATA_W{1'b0}};
      cipo_oe_r   <= 1'b0;
      wr_stb_r    <= {NUM_REGS{1'b0}};
      frame_err_r <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= RESET_VAL;
      end
    end else begin
      wr_stb_r    <= {NUM_REGS{1'b0}};
      frame_err_r <= err_s;
      commit_r    <= 1'b0;
      rd_load_r   <= 1'b0;
      // A completed write word commits even if ncs rises in the same cycle.
      if (commit_r) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (ptr_r == ADDR_W'(i)) begin
            regs_r[i]   <= shift_r;
            wr_stb_r[i] <= 1'b1;
          end
        end
        ptr_r <= ptr_r + ADDR_W'(1);
      end
      case (state_r)
        IDLE: begin
          rd_shift_r <= {DATA_W{1'b0}};
          cipo_oe_r  <= 1'b0;
          if (ncs_fall_s) begin
            bit_cnt_r <= {CNT_W{1'b0}};
            shift_r   <= {DATA_W{1'b0}};
          end
        end
        CMD: begin
          if (ncs_rise_s) begin
            rd_shift_r <= {DATA_W{1'b0}};
            cipo_oe_r  <= 1'b0;
          end else if (sclk_rise_s) begin
            if (bit_cnt_r == {CNT_W{1'b0}}) begin
              rw_r <= copi_s;
            end else begin
              ptr_r <= {ptr_r[ADDR_W-2:0], copi_s};
            end
            if (hdr_last_s) begin
              bit_cnt_r <= {CNT_W{1'b0}};
              rd_load_r <= ~rw_r;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (ncs_rise_s) begin
            rd_shift_r <= {DATA_W{1'b0}};
            cipo_oe_r  <= 1'b0;
          end else begin
            if (sclk_rise_s) begin
              shift_r <= {shift_r[DATA_W-2:0], copi_s};
              if (word_last_s) begin
                bit_cnt_r <= {CNT_W{1'b0}};
                if (rw_r) begin
                  commit_r <= 1'b1;
                end else begin
                  ptr_r     <= ptr_r + ADDR_W'(1);
                  rd_load_r <= 1'b1;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              end
            end
            // The first falling edge after a load presents the MSB rather than shifting it out.
            if (sclk_fall_s && cipo_oe_r) begin
              if (rd_hold_r) begin
                rd_hold_r <= 1'b0;
              end else begin
                rd_shift_r <= {rd_shift_r[DATA_W-2:0], 1'b0};
              end
            end
            if (rd_load_r) begin
              rd_shift_r <= rd_word_s;
              cipo_oe_r  <= 1'b1;
              rd_hold_r  <= 1'b1;
            end
          end
        end
        default: begin
          rd_shift_r <= {DATA_W{1'b0}};
          cipo_oe_r  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_r[g];
  end

  assign wr_stb      = wr_stb_r;
  assign frame_err   = frame_err_r;
  assign spi.cipo    = rd_shift_r[DATA_W-1];
  assign spi.cipo_oe = cipo_oe_r;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench for spi_regfile_peripheral: stimulus pushes expected strobes,
// errors and cipo bits; monitors pop and compare whenever the DUT produces them.
module tb_spi_regfile_peripheral;
  localparam int        NUM_REGS = 5;
  localparam int        DATA_W   = 8;
  localparam int        ADDR_W   = 7;
  localparam int        HALF     = 6;
  localparam logic [7:0] RV      = 8'hA5;

  typedef struct {
    logic [NUM_REGS-1:0] stb;
    logic [DATA_W-1:0]   data;
  } wr_exp_t;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [NUM_REGS*DATA_W-1:0]  regs_flat;
  logic [NUM_REGS-1:0]         wr_stb;
  logic                        frame_err;

  spi_regfile_peripheral_if spi ();

  spi_regfile_peripheral #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .SYNC_STAGES(2), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi(spi),
    .regs_flat(regs_flat), .wr_stb(wr_stb), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  wr_exp_t    wr_q[$];
  int         err_q[$];
  logic       rd_q[$];
  logic [7:0] model [NUM_REGS];
  int         checks = 0;
  int         passes = 0;
  wr_exp_t    mon_e;
  int         mon_idx;
  int         mon_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_regs(input string name);
    logic [NUM_REGS*DATA_W-1:0] exp;
    for (int i = 0; i < NUM_REGS; i++) exp[i*DATA_W +: DATA_W] = model[i];
    check(name, 64'(regs_flat), 64'(exp));
  endtask

  task automatic frame(input logic [47:0] bits, input int n, input bit raise);
    spi.ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      spi.copi = bits[i];
      repeat (HALF) @(negedge clk);
      spi.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi.sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    if (raise) begin
      spi.ncs  = 1'b1;
      spi.copi = 1'b0;
      repeat (12) @(negedge clk);
      check("cipo_oe_after_frame", 64'(spi.cipo_oe), 64'd0);
      check("cipo_after_frame", 64'(spi.cipo), 64'd0);
    end
  endtask

  task automatic push_wr(input int idx, input logic [7:0] data);
    wr_exp_t e;
    e.stb  = NUM_REGS'(1) << idx;
    e.data = data;
    wr_q.push_back(e);
    model[idx] = data;
  endtask

  task automatic push_rd(input logic [7:0] data);
    for (int i = 7; i >= 0; i--) rd_q.push_back(data[i]);
  endtask

  // Write-strobe and frame-error monitor.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wr_stb !== {NUM_REGS{1'b0}}) begin
        if (wr_q.size() == 0) begin
          check("unexpected_wr_stb", 64'(wr_stb), 64'd0);
        end else begin
          mon_e = wr_q.pop_front();
          mon_idx = 0;
          for (int i = 0; i < NUM_REGS; i++) if (mon_e.stb[i]) mon_idx = i;
          check("wr_stb", 64'(wr_stb), 64'(mon_e.stb));
          check("wr_data", 64'(regs_flat[mon_idx*DATA_W +: DATA_W]), 64'(mon_e.data));
        end
      end
      if (frame_err !== 1'b0) begin
        if (err_q.size() == 0) begin
          check("unexpected_frame_err", 64'(frame_err), 64'd0);
        end else begin
          mon_err = err_q.pop_front();
          check("frame_err", 64'(frame_err), 64'(mon_err));
        end
      end
    end
  end

  // cipo monitor: the controller samples on rising sclk.
  always @(posedge spi.sclk) begin
    if (spi.cipo_oe === 1'b1) begin
      if (rd_q.size() == 0) check("unexpected_cipo_oe", 64'(spi.cipo_oe), 64'd0);
      else check("cipo_bit", 64'(spi.cipo), 64'(rd_q.pop_front()));
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    spi.sclk = 1'b0;
    spi.ncs  = 1'b1;
    spi.copi = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = RV;
    repeat (3) @(negedge clk);
    check_regs("reset_regs");
    check("reset_cipo_oe", 64'(spi.cipo_oe), 64'd0);
    check("reset_wr_stb", 64'(wr_stb), 64'd0);
    check("reset_frame_err", 64'(frame_err), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single write to reg2.
    push_wr(2, 8'hF0);
    frame({1'b1, 7'h02, 8'hF0}, 16, 1'b1);
    check_regs("single_write_regs");

    // Burst from reg3; the third word lands on address 5 and is dropped.
    push_wr(3, 8'h11);
    push_wr(4, 8'h22);
    frame({1'b1, 7'h03, 8'h11, 8'h22, 8'h33}, 32, 1'b1);
    check_regs("burst_regs");

    // Burst read-back from reg3.
    push_rd(8'h11);
    push_rd(8'h22);
    frame({1'b0, 7'h03, 16'h0000}, 24, 1'b1);
    check_regs("read_regs_unchanged");

    // Out-of-range read returns zero.
    push_rd(8'h00);
    frame({1'b0, 7'h05, 8'h00}, 16, 1'b1);

    // Partial word then a clean frame to reg0.
    err_q.push_back(1);
    frame({1'b1, 7'h00, 5'b10110}, 13, 1'b1);
    check_regs("partial_regs");
    push_wr(0, 8'h3C);
    frame({1'b1, 7'h00, 8'h3C}, 16, 1'b1);
    check_regs("after_partial_regs");

    // Header-only abort is an error too.
    err_q.push_back(1);
    frame({1'b1, 3'b000}, 4, 1'b1);
    check_regs("short_header_regs");

    // Reset in the middle of a write to reg1.
    frame({1'b1, 7'h01, 2'b10}, 10, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    spi.ncs  = 1'b1;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = RV;
    repeat (2) @(negedge clk);
    check("midreset_cipo_oe", 64'(spi.cipo_oe), 64'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_regs("midreset_regs");
    push_wr(1, 8'h5A);
    frame({1'b1, 7'h01, 8'h5A}, 16, 1'b1);
    check_regs("after_reset_write_regs");

    repeat (20) @(negedge clk);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    check("err_q_drained", 64'(err_q.size()), 64'd0);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
